led_vu_ctrl: RTL and testbench

- Stereo VU-meter controller that sequences the 8-LED bar from equalizer output samples.
- Per channel: takes the signed 16-bit sample on each vld and forms its saturated magnitude.
- Tracks the peak with a hold/decay state machine and maps the peak to a 4-segment thermometer.
- Gates each lit segment with the channel PDM bit so brightness follows the audio. Sits between the equalizer output stage and the board LEDs.

---
 rtl/led_vu_ctrl_if.sv | 20 ++
 rtl/led_vu_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_vu_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/led_vu_ctrl_if.sv
// Sample/PDM/LED bundle between the equalizer output stage and the VU-meter controller.
// The master drives samples and PDM bits; the slave (controller) drives the LED bar.
interface led_vu_ctrl_if;
    logic        vld;
    logic [15:0] aud_out_lft;
    logic [15:0] aud_out_rght;
    logic        lft_PDM;
    logic        rght_PDM;
    logic [7:0]  LED;

    modport master (
        output vld, aud_out_lft, aud_out_rght, lft_PDM, rght_PDM,
        input  LED
    );

    modport slave (
        input  vld, aud_out_lft, aud_out_rght, lft_PDM, rght_PDM,
        output LED
    );
endinterface

// File: rtl/led_vu_ctrl.sv
// Stereo VU-meter: per-channel saturated magnitude, peak hold/decay FSM, thermometer
// level and PDM-gated 8-LED bar (left half mirrored toward the centre).
module led_vu_ctrl #(
    parameter int          HOLD_CYC   = 16,
    parameter int          DECAY_SHFT = 3,
    parameter logic [15:0] THR0       = 16'h0010,
    parameter logic [15:0] THR1       = 16'h0100,
    parameter logic [15:0] THR2       = 16'h0800,
    parameter logic [15:0] THR3       = 16'h2000
) (
    input  logic         clk,
    input  logic         rst,
    led_vu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        DECAY = 2'd2
    } pk_state_t;

    // |sample| in 15 bits; the most negative code clamps instead of wrapping to zero.
    function automatic logic [14:0] sat_mag(input logic [15:0] smp);
        logic [14:0] res_v;
        if (smp == 16'h8000) begin
            res_v = 15'h7FFF;
        end else if (smp[15]) begin
            res_v = ~smp[14:0] + 15'd1;
        end else begin
            res_v = smp[14:0];
        end
        return res_v;
    endfunction

    logic [3:0] lvl_l_s;
    logic [3:0] lvl_r_s;
    logic [7:0] led_r;

    // Channel 0 is left, channel 1 is right; both are identical.
    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic [15:0] smp_s;
        logic [14:0] mag_s;
        logic [14:0] step_s;
        logic [14:0] dec_s;
        logic        reload_s;
        logic [14:0] peak_r;
        logic [7:0]  cnt_r;
        pk_state_t   state_r;
        logic [3:0]  lvl_r;

        assign smp_s    = (ch == 0) ? bus.aud_out_lft : bus.aud_out_rght;
        assign mag_s    = sat_mag(smp_s);
        assign reload_s = (mag_s != 15'd0) && (mag_s >= peak_r);

        // Decay step of at least one LSB, clamped so the peak lands exactly on zero.
        always_comb begin
            step_s = 15'(peak_r >> DECAY_SHFT);
            dec_s  = 15'd0;
            if (step_s == 15'd0) begin
                step_s = 15'd1;
            end else begin
                step_s = 15'(peak_r >> DECAY_SHFT);
            end
            if (peak_r > step_s) begin
                dec_s = peak_r - step_s;
            end else begin
                dec_s = 15'd0;
            end
        end

        // Peak hold/decay FSM; advances only on vld, reload wins over hold and decay.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                peak_r  <= 15'd0;
                cnt_r   <= 8'd0;
                state_r <= IDLE;
            end else if (bus.vld) begin
                if (reload_s) begin
                    peak_r  <= mag_s;
                    cnt_r   <= 8'(HOLD_CYC);
                    state_r <= HOLD;
                end else begin
                    case (state_r)
                        IDLE: begin
                            peak_r <= 15'd0;
                        end
                        HOLD: begin
                            cnt_r <= cnt_r - 8'd1;
                            if (cnt_r == 8'd1) begin
                                state_r <= DECAY;
                            end else begin
                                state_r <= HOLD;
                            end
                        end
                        DECAY: begin
                            peak_r <= dec_s;
                            if (dec_s == 15'd0) begin
                                state_r <= IDLE;
                            end else begin
                                state_r <= DECAY;
                            end
                        end
                        default: begin
                            peak_r  <= 15'd0;
                            cnt_r   <= 8'd0;
                            state_r <= IDLE;
                        end
                    endcase
                end
            end else begin
                state_r <= state_r;
            end
        end

        // Thermometer level from the zero-extended peak, refreshed every clock.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lvl_r <= 4'h0;
            end else begin
                lvl_r <= {({1'b0, peak_r} >= THR3), ({1'b0, peak_r} >= THR2),
                          ({1'b0, peak_r} >= THR1), ({1'b0, peak_r} >= THR0)};
            end
        end
    end

    assign lvl_l_s = g_ch[0].lvl_r;
    assign lvl_r_s = g_ch[1].lvl_r;

    // LED bar: right grows upward from LED[4], left grows downward from LED[3].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r <= 8'h00;
        end else begin
            led_r <= {lvl_r_s & {4{bus.rght_PDM}},
                      {lvl_l_s[0], lvl_l_s[1], lvl_l_s[2], lvl_l_s[3]} & {4{bus.lft_PDM}}};
        end
    end

    assign bus.LED = led_r;

endmodule

// File: tb/tb_led_vu_ctrl.sv
// Directed bench for led_vu_ctrl: thresholds, saturation, mirroring, hold/decay, reset.
module tb_led_vu_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    led_vu_ctrl_if bus ();

    led_vu_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle vld pulse; returns at the falling edge right after the sampling edge.
    task automatic send(input logic [15:0] l, input logic [15:0] r);
        bus.vld          = 1'b1;
        bus.aud_out_lft  = l;
        bus.aud_out_rght = r;
        @(negedge clk);
        bus.vld          = 1'b0;
        bus.aud_out_lft  = 16'h0000;
        bus.aud_out_rght = 16'h0000;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [14:0] exp_pk;
        int          steps;
        rst              = 1'b1;
        bus.vld          = 1'b0;
        bus.aud_out_lft  = 16'h0000;
        bus.aud_out_rght = 16'h0000;
        bus.lft_PDM      = 1'b0;
        bus.rght_PDM     = 1'b0;
        idle(2);
        check("reset_led", 32'(bus.LED), 32'h00);
        check("reset_peak_l", 32'(dut.g_ch[0].peak_r), 32'h0);
        check("reset_state_r", 32'(dut.g_ch[1].state_r), 32'd0);
        rst = 1'b0;

        // Right-channel thresholds with PDM tied high.
        bus.lft_PDM  = 1'b1;
        bus.rght_PDM = 1'b1;
        send(16'h0000, 16'h0100);
        idle(2);
        check("thr_0100", 32'(bus.LED), 32'h30);
        send(16'h0000, 16'h2000);
        idle(2);
        check("thr_2000", 32'(bus.LED), 32'hF0);
        send(16'h0000, 16'hE000);
        idle(2);
        check("thr_E000", 32'(bus.LED), 32'hF0);
        check("equal_reload_cnt", 32'(dut.g_ch[1].cnt_r), 32'd16);
        check("equal_reload_state", 32'(dut.g_ch[1].state_r), 32'd1);

        // Asynchronous reset with the right bar fully lit.
        rst = 1'b1;
        #1;
        check("async_rst_led", 32'(bus.LED), 32'h00);
        check("async_rst_peak", 32'(dut.g_ch[1].peak_r), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        check("post_rst_dark", 32'(bus.LED), 32'h00);

        // Saturation and left mirroring / PDM gating.
        send(16'h8000, 16'h0000);
        check("sat_peak", 32'(dut.g_ch[0].peak_r), 32'h7FFF);
        idle(2);
        check("sat_led", 32'(bus.LED), 32'h0F);
        bus.lft_PDM = 1'b0;
        @(negedge clk);
        check("pdm_0", 32'(bus.LED), 32'h00);
        bus.lft_PDM = 1'b1;
        @(negedge clk);
        check("pdm_1", 32'(bus.LED), 32'h0F);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // Hold then decay on the left channel.
        send(16'h1000, 16'h0000);
        repeat (15) send(16'h0000, 16'h0000);
        check("hold15_state", 32'(dut.g_ch[0].state_r), 32'd1);
        check("hold15_cnt", 32'(dut.g_ch[0].cnt_r), 32'd1);
        send(16'h0000, 16'h0000);
        check("hold16_state", 32'(dut.g_ch[0].state_r), 32'd2);
        check("hold16_peak", 32'(dut.g_ch[0].peak_r), 32'h1000);
        send(16'h0000, 16'h0000);
        check("decay17_peak", 32'(dut.g_ch[0].peak_r), 32'h0E00);
        send(16'h0000, 16'h0000);
        check("decay18_peak", 32'(dut.g_ch[0].peak_r), 32'h0C40);
        idle(2);
        check("decay_led", 32'(bus.LED), 32'h0E);

        // Smaller sample during decay does not reload; equal sample does.
        send(16'h0100, 16'h0000);
        check("no_reload_peak", 32'(dut.g_ch[0].peak_r), 32'h0AB8);
        check("no_reload_state", 32'(dut.g_ch[0].state_r), 32'd2);
        send(16'h0AB8, 16'h0000);
        check("reload_state", 32'(dut.g_ch[0].state_r), 32'd1);
        check("reload_cnt", 32'(dut.g_ch[0].cnt_r), 32'd16);
        check("reload_peak", 32'(dut.g_ch[0].peak_r), 32'h0AB8);

        // Run hold out, then follow the decay to zero against a bench model.
        repeat (16) send(16'h0000, 16'h0000);
        exp_pk = 15'h0AB8;
        steps  = 0;
        while (exp_pk != 15'd0 && steps < 200) begin
            exp_pk = exp_pk - (((exp_pk >> 3) == 15'd0) ? 15'd1 : (exp_pk >> 3));
            send(16'h0000, 16'h0000);
            check("decay_step", 32'(dut.g_ch[0].peak_r), 32'(exp_pk));
            steps++;
        end
        check("decay_idle", 32'(dut.g_ch[0].state_r), 32'd0);
        idle(2);
        check("decay_led_dark", 32'(bus.LED), 32'h00);

        // Right-only activity leaves the left bar dark; no vld freezes state.
        send(16'h0000, 16'h0400);
        idle(2);
        check("indep_led_a", 32'(bus.LED), 32'h30);
        send(16'h0000, 16'h0400);
        idle(2);
        check("indep_led_b", 32'(bus.LED), 32'h30);
        check("indep_left_peak", 32'(dut.g_ch[0].peak_r), 32'h0);
        idle(100);
        check("gap_peak", 32'(dut.g_ch[1].peak_r), 32'h0400);
        check("gap_cnt", 32'(dut.g_ch[1].cnt_r), 32'd16);
        check("gap_led", 32'(bus.LED), 32'h30);

        // vld held high for three cycles counts as three samples.
        bus.vld = 1'b1;
        idle(3);
        bus.vld = 1'b0;
        check("burst_cnt", 32'(dut.g_ch[1].cnt_r), 32'd13);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
